// File: rtl/and_or_reg_pkg.sv
// Shared index constants for the AND/OR register trio: which variant sits in
// which output bit, and which input bit carries a, b and c.
package and_or_reg_pkg;

   localparam int unsigned VAR_SAME_CYCLE = 0;
   localparam int unsigned VAR_BLOCK2     = 1;
   localparam int unsigned VAR_NOBLOCK1   = 2;

   localparam int unsigned IDX_A = 0;
   localparam int unsigned IDX_B = 1;
   localparam int unsigned IDX_C = 2;

endpackage

// File: rtl/and_or_reg_stage.sv
// One registered AND/OR evaluator. PIPE_G=0 builds g from the same-cycle
// product; PIPE_G=1 builds g from the product registered on the previous edge.
module and_or_reg_stage #(
   parameter int unsigned PIPE_G = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic a,
   input  logic b,
   input  logic c,
   output logic f,
   output logic g
);

   logic g_next;

   generate
      if (PIPE_G != 0) begin : g_pipe
         // f still holds the product from before this edge
         assign g_next = f | c;
      end else begin : g_same
         assign g_next = (a & b) | c;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         f <= 1'b0;
         g <= 1'b0;
      end else begin
         f <= a & b;
         g <= g_next;
      end
   end

endmodule

// File: rtl/and_or_reg_trio.sv
// Three side-by-side AND/OR evaluators: one single-stage form and two
// independent two-stage forms of f = a & b, g = f | c.
module and_or_reg_trio
   import and_or_reg_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] x,
   output logic [2:0] f,
   output logic [2:0] g
);

   logic a;
   logic b;
   logic c;

   assign a = x[IDX_A];
   assign b = x[IDX_B];
   assign c = x[IDX_C];

   and_or_reg_stage #(.PIPE_G(0)) u_same_cycle (
      .clk   (clk),
      .reset (reset),
      .a     (a),
      .b     (b),
      .c     (c),
      .f     (f[VAR_SAME_CYCLE]),
      .g     (g[VAR_SAME_CYCLE])
   );

   and_or_reg_stage #(.PIPE_G(1)) u_block2 (
      .clk   (clk),
      .reset (reset),
      .a     (a),
      .b     (b),
      .c     (c),
      .f     (f[VAR_BLOCK2]),
      .g     (g[VAR_BLOCK2])
   );

   and_or_reg_stage #(.PIPE_G(1)) u_noblock1 (
      .clk   (clk),
      .reset (reset),
      .a     (a),
      .b     (b),
      .c     (c),
      .f     (f[VAR_NOBLOCK1]),
      .g     (g[VAR_NOBLOCK1])
   );

endmodule

// File: tb/tb_and_or_reg_trio.sv
// Bench for and_or_reg_trio: fixed vector table from the cycle rules, an
// edge-only sampling sequence, then randomized traffic against a reference model.
module tb_and_or_reg_trio;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] x;
   logic [2:0] f;
   logic [2:0] g;

   int checks = 0;
   int errors = 0;

   // product a&b of the previous sample, as seen by the pipelined variants
   logic prev_ab = 1'b0;

   typedef struct {
      string      name;
      logic       rst;
      logic [2:0] xv;
      logic [2:0] ef;
      logic [2:0] eg;
   } vec_t;

   vec_t tbl[$];

   and_or_reg_trio dut (
      .clk   (clk),
      .reset (reset),
      .x     (x),
      .f     (f),
      .g     (g)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // drive on the falling edge, sample 1 time unit after the rising edge
   task automatic step(input logic r, input logic [2:0] xv);
      @(negedge clk);
      reset = r;
      x     = xv;
      @(posedge clk);
      #1;
      prev_ab = r ? 1'b0 : (xv[0] & xv[1]);
   endtask

   initial begin
      logic       ab;
      logic       c;
      logic       r;
      logic [2:0] xv;
      logic [2:0] ef;
      logic [2:0] eg;

      reset = 1'b1;
      x     = 3'b000;

      tbl.push_back('{"reset",      1'b1, 3'b111, 3'b000, 3'b000});
      tbl.push_back('{"pipe_a",     1'b0, 3'b011, 3'b111, 3'b001});
      tbl.push_back('{"pipe_b",     1'b0, 3'b000, 3'b000, 3'b110});
      tbl.push_back('{"reset2",     1'b1, 3'b000, 3'b000, 3'b000});
      tbl.push_back('{"or_path",    1'b0, 3'b100, 3'b000, 3'b111});
      tbl.push_back('{"reset3",     1'b1, 3'b000, 3'b000, 3'b000});
      tbl.push_back('{"sweep0",     1'b0, 3'b000, 3'b000, 3'b000});
      tbl.push_back('{"sweep1",     1'b0, 3'b001, 3'b000, 3'b000});
      tbl.push_back('{"sweep2",     1'b0, 3'b010, 3'b000, 3'b000});
      tbl.push_back('{"sweep3",     1'b0, 3'b011, 3'b111, 3'b001});
      tbl.push_back('{"sweep4",     1'b0, 3'b100, 3'b000, 3'b111});
      tbl.push_back('{"sweep5",     1'b0, 3'b101, 3'b000, 3'b111});
      tbl.push_back('{"sweep6",     1'b0, 3'b110, 3'b000, 3'b111});
      tbl.push_back('{"sweep7",     1'b0, 3'b111, 3'b111, 3'b111});
      tbl.push_back('{"mid_a",      1'b0, 3'b011, 3'b111, 3'b111});
      tbl.push_back('{"mid_b",      1'b0, 3'b011, 3'b111, 3'b111});
      tbl.push_back('{"mid_reset",  1'b1, 3'b011, 3'b000, 3'b000});
      tbl.push_back('{"mid_after",  1'b0, 3'b000, 3'b000, 3'b000});

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].xv);
         check({tbl[i].name, "_f"}, f, tbl[i].ef);
         check({tbl[i].name, "_g"}, g, tbl[i].eg);
         check({tbl[i].name, "_g1g2"}, {2'b00, g[1]}, {2'b00, g[2]});
      end

      // x wiggles between edges must not reach the outputs
      step(1'b0, 3'b011);
      check("hold_f0", f, 3'b111);
      check("hold_g0", g, 3'b001);
      x = 3'b100;
      #1;
      check("hold_f1", f, 3'b111);
      check("hold_g1", g, 3'b001);
      x = 3'b000;
      #1;
      x = 3'b111;
      #1;
      check("hold_f2", f, 3'b111);
      check("hold_g2", g, 3'b001);
      step(1'b0, 3'b000);
      check("hold_next_f", f, 3'b000);
      check("hold_next_g", g, 3'b110);

      // randomized traffic against the cycle rules
      for (int n = 0; n < 300; n++) begin
         r  = ($urandom_range(0, 15) == 0);
         xv = 3'($urandom_range(0, 7));
         ab = xv[0] & xv[1];
         c  = xv[2];
         if (r) begin
            ef = 3'b000;
            eg = 3'b000;
         end else begin
            ef = {3{ab}};
            eg = {prev_ab | c, prev_ab | c, ab | c};
         end
         step(r, xv);
         check("rand_f", f, ef);
         check("rand_g", g, eg);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
